pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EXE) for load-use, taken-branch and multi-cycle mul/div events.
//  Drives the ID/EXE bubble input (wrn, active-low) plus the PC and IF/ID enables.
//  Keeps a saturating stall-cycle performance counter.
//  Sits beside the decoder; all inputs come from the ID stage and from ID/EXE register outputs.
// PARAMETERS
//  MD_LAT  4   total EXE cycles of a mul/div op incl. issue cycle; legal range 1..16
//  CNT_W   16  width of stall_cnt
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low reset
//  id_rs        in   5      rs field of instruction in ID
//  id_rt        in   5      rt field of instruction in ID
//  id_use_rs    in   1      ID instruction reads rs
//  id_use_rt    in   1      ID instruction reads rt
//  id_md_start  in   1      ID instruction is mul/div
//  ex_rw        in   5      destination reg of instruction in EXE
//  ex_reg_write in   1      EXE instruction writes the register file
//  ex_memtoreg  in   1      EXE instruction is a load
//  ex_br_taken  in   1      branch/jump in EXE resolved taken
//  pc_en        out  1      1 = PC loads next value
//  ifid_en      out  1      1 = IF/ID captures; 0 = holds
//  ifid_flush   out  1      1 = IF/ID loads zero (NOP) at next edge
//  idexe_wrn    out  1      0 = ID/EXE loads zero bubble at next edge
//  md_busy      out  1      1 while in MD_WAIT
//  stall_cnt    out  CNT_W  count of cycles with pc_en==0
// BEHAVIOUR
//  State: RUN, MD_WAIT; md_cnt is 4 bits. Outputs combinational from state + inputs.
//  Reset (reset==0, async): state=RUN, md_cnt=0, stall_cnt=0.
//   While reset is held: pc_en=0, ifid_en=0, ifid_flush=0, idexe_wrn=0, md_busy=0.
//  lu_haz = ex_memtoreg & ex_reg_write & (ex_rw!=0) &
//           ((id_use_rs & id_rs==ex_rw) | (id_use_rt & id_rt==ex_rw)).
//  RUN, priority high->low:
//   1. ex_br_taken: pc_en=1, ifid_en=1, ifid_flush=1, idexe_wrn=0 (kills IF and ID); lu_haz and id_md_start ignored.
//   2. lu_haz: pc_en=0, ifid_en=0, idexe_wrn=0. Exactly 1 bubble; the next cycle re-evaluates (load is then in MEM, so no hazard).
//   3. id_md_start & MD_LAT>1: pc_en=1, ifid_en=1, idexe_wrn=1 (op issues); md_cnt<=MD_LAT-1; next state MD_WAIT.
//   4. else: pc_en=1, ifid_en=1, ifid_flush=0, idexe_wrn=1.
//  MD_WAIT: pc_en=0, ifid_en=0, ifid_flush=0, idexe_wrn=0, md_busy=1. Instruction after mul/div waits in ID; bubbles enter EXE.
//   md_cnt decrements each edge; when md_cnt==1 at an edge, next state is RUN.
//   MD_WAIT therefore lasts exactly MD_LAT-1 cycles.
//   ex_br_taken, lu_haz and id_md_start are ignored; EXE holds only bubbles, so ex_br_taken=1 is a bench assertion failure.
//  MD_LAT==1: MD_WAIT is never entered; mul/div behaves as a normal op.
//  stall_cnt: +1 at each edge where pc_en==0 and reset==1; saturates at all-ones, no wrap.
//  Reset asserted mid MD_WAIT or mid stall aborts immediately to the reset values above.
//  Reset release: first edge after deassertion evaluates RUN rules.
//  ifid_flush and ifid_en both 1 only in branch case; IF/ID gives flush priority.
// TESTING
//  T1 lw r5 in EXE (ex_memtoreg=1, ex_rw=5), ID add reads rs=5 ->
//     1 cycle pc_en=0/ifid_en=0/idexe_wrn=0; next cycle all 1; stall_cnt=1.
//  T2 same as T1 with ex_rw=0, or id_use_rs=0 -> no stall; stall_cnt stays 0.
//  T3 ex_br_taken=1 together with lu_haz=1 -> ifid_flush=1, idexe_wrn=0, pc_en=1; stall_cnt unchanged.
//  T4 MD_LAT=4, id_md_start=1 -> issue cycle normal, then md_busy=1 for exactly 3 cycles with pc_en=0;
//     RUN resumes; stall_cnt=3.
//  T5 reset pulsed low in 2nd MD_WAIT cycle -> md_busy=0, stall_cnt=0 asynchronously;
//     RUN after release. MD_LAT=1 -> no MD_WAIT.
//  T6 CNT_W=4, hold lu_haz for 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC / IF-ID / ID-EXE sequencing for load-use, taken-branch and multi-cycle mul/div,
// with a saturating count of cycles in which the PC was held.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_start,
  input  logic [4:0]       ex_rw,
  input  logic             ex_reg_write,
  input  logic             ex_memtoreg,
  input  logic             ex_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idexe_wrn,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic {RUN, MD_WAIT} state_t;
  state_t           state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu_haz;
  assign lu_haz = ex_memtoreg & ex_reg_write & (ex_rw != '0) &
                  ((id_use_rs & (id_rs == ex_rw)) | (id_use_rt & (id_rt == ex_rw)));
  assign stall_cnt = stall_cnt_q;
  always_comb begin
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idexe_wrn  = 1'b1;
    md_busy    = 1'b0;
    if (!reset) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idexe_wrn = 1'b0;
    end else if (state_q == MD_WAIT) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idexe_wrn = 1'b0;
      md_busy   = 1'b1;
      md_cnt_d  = md_cnt_q - 4'd1;
      state_d   = (md_cnt_q == 4'd1) ? RUN : MD_WAIT;
    end else if (ex_br_taken) begin
      ifid_flush = 1'b1;
      idexe_wrn  = 1'b0;
    end else if (lu_haz) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idexe_wrn = 1'b0;
    end else if (id_md_start && MD_LAT > 1) begin
      md_cnt_d = 4'(MD_LAT - 1);
      state_d  = MD_WAIT;
    end
    stall_cnt_d = (!pc_en && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: three configurations driven in lockstep, checked through a scoreboard
// against a cycle-level model of the hazard rules.
module tb_pipe_hazard_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rw = '0;
  logic id_use_rs = 0, id_use_rt = 0, id_md_start = 0, ex_reg_write = 0, ex_memtoreg = 0, ex_br_taken = 0;
  logic [4:0] o0, o1, o2;
  logic [15:0] s0;
  logic [3:0] s1;
  logic [7:0] s2;
  int total = 0, bad = 0;
  typedef struct {int d; logic [4:0] o; int sc;} exp_t;
  exp_t sb[$];
  int lat[3] = '{4, 1, 16};
  int smax[3] = '{65535, 15, 255};
  int wait_left[3] = '{0, 0, 0};
  int cnt[3] = '{0, 0, 0};

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) u0 (.clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md_start(id_md_start), .ex_rw(ex_rw),
    .ex_reg_write(ex_reg_write), .ex_memtoreg(ex_memtoreg), .ex_br_taken(ex_br_taken),
    .pc_en(o0[4]), .ifid_en(o0[3]), .ifid_flush(o0[2]), .idexe_wrn(o0[1]), .md_busy(o0[0]), .stall_cnt(s0));
  pipe_hazard_ctrl #(.MD_LAT(1), .CNT_W(4)) u1 (.clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md_start(id_md_start), .ex_rw(ex_rw),
    .ex_reg_write(ex_reg_write), .ex_memtoreg(ex_memtoreg), .ex_br_taken(ex_br_taken),
    .pc_en(o1[4]), .ifid_en(o1[3]), .ifid_flush(o1[2]), .idexe_wrn(o1[1]), .md_busy(o1[0]), .stall_cnt(s1));
  pipe_hazard_ctrl #(.MD_LAT(16), .CNT_W(8)) u2 (.clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md_start(id_md_start), .ex_rw(ex_rw),
    .ex_reg_write(ex_reg_write), .ex_memtoreg(ex_memtoreg), .ex_br_taken(ex_br_taken),
    .pc_en(o2[4]), .ifid_en(o2[3]), .ifid_flush(o2[2]), .idexe_wrn(o2[1]), .md_busy(o2[0]), .stall_cnt(s2));

  // Expected outputs bits: {pc_en, ifid_en, ifid_flush, idexe_wrn, md_busy}
  task automatic cyc(input logic r, br, ld, wr, input logic [4:0] rw, rs, rt, input logic urs, urt, md);
    logic lu;
    logic [4:0] e;
    @(negedge clock);
    #1;
    reset = r; ex_br_taken = br; ex_memtoreg = ld; ex_reg_write = wr; ex_rw = rw;
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_md_start = md;
    lu = ld && wr && rw != 0 && ((urs && rs == rw) || (urt && rt == rw));
    for (int d = 0; d < 3; d++) begin
      if (!r) e = 5'b00000;
      else if (wait_left[d] > 0) e = 5'b00001;
      else if (br) e = 5'b11100;
      else if (lu) e = 5'b00000;
      else e = 5'b11010;
      sb.push_back('{d, e, r ? cnt[d] : 0});
      if (!r) begin
        wait_left[d] = 0;
        cnt[d] = 0;
      end else begin
        if (!e[4] && cnt[d] < smax[d]) cnt[d]++;
        if (wait_left[d] > 0) wait_left[d]--;
        else if (!br && !lu && md) wait_left[d] = lat[d] - 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    exp_t x;
    logic [4:0] ao;
    int as;
    forever begin
      @(negedge clock);
      #3;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        ao = x.d == 0 ? o0 : x.d == 1 ? o1 : o2;
        as = x.d == 0 ? int'(s0) : x.d == 1 ? int'(s1) : int'(s2);
        total++;
        if (ao !== x.o) begin
          bad++;
          $display("FAIL ctl dut%0d t=%0t got=%b want=%b", x.d, $time, ao, x.o);
        end
        total++;
        if (as != x.sc) begin
          bad++;
          $display("FAIL stall_cnt dut%0d t=%0t got=%0d want=%0d", x.d, $time, as, x.sc);
        end
      end
    end
  end

  initial begin
    logic br, any_wait;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 5, 5, 5, 1, 1, 1);
    idle(2);
    cyc(1, 0, 1, 1, 5, 5, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 5, 5, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 5, 5, 5, 0, 0, 0);
    cyc(1, 0, 1, 1, 5, 1, 5, 0, 1, 0);
    cyc(1, 0, 1, 0, 5, 5, 5, 1, 1, 0);
    cyc(1, 1, 1, 1, 5, 5, 0, 1, 0, 1);
    idle(1);
    cyc(1, 0, 0, 0, 0, 1, 2, 1, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 3, 3, 3, 1, 1, 1);
    idle(16);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(16);
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, 1, 7, 7, 0, 1, 0, 0);
    idle(2);
    for (int i = 0; i < 2500; i++) begin
      any_wait = wait_left[0] > 0 || wait_left[1] > 0 || wait_left[2] > 0;
      br = !any_wait && $urandom_range(0, 5) == 0;
      cyc($urandom_range(0, 60) != 0, br, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
          $urandom_range(0, 7) == 0);
    end
    repeat (3) @(negedge clock);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
